// File: rtl/dmem_responder.sv
// Data-memory responder: turns core load/store requests into single SRAM word accesses.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module dmem_responder #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WrData,
    output logic [31:0]       RdData,
    output logic              Stall,
    output logic              MisalignErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              misalign_q, misalign_d;
    logic              trap;
    logic              unused_addr;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'h0, h};
            default: load_ext = rdata;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    // Undefined Funct3 encodings decode as word (Funct3[1] set), so they trap like lw/sw.
    assign trap = ((Funct3[1:0] == 2'b01) && Addr[0]) || (Funct3[1] && (Addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign unused_addr = ^Addr[31:ADDR_W+2];

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        misalign_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    mem_we_d    = MemWrite;
                    mem_addr_d  = Addr[ADDR_W+1:2];
                    mem_be_d    = MemWrite ? store_be(Funct3, Addr[1:0]) : 4'b1111;
                    mem_wdata_d = store_data(Funct3, WrData);
                    off_d       = Addr[1:0];
                    funct3_d    = Funct3;
                    if (trap) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        rd_data_d  = 32'h0;
                    end else begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                    end
                end
            end
            REQ, WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_we_q) begin
                        rd_data_d = load_ext(funct3_q, off_q, mem_rdata);
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            rd_data_q   <= 32'h0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            misalign_q  <= misalign_d;
        end
    end

    // The core must see Stall drop in the same cycle the result is presented.
    assign Stall       = (MemRead || MemWrite) && (state_q != DONE);
    assign RdData      = rd_data_q;
    assign MisalignErr = misalign_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a behavioural SRAM with programmable wait states.
module tb_dmem_responder;

    localparam int ADDR_W = 9;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        chk_rd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [2:0]        Funct3 = 3'b000;
    logic [31:0]       Addr = 32'h0;
    logic [31:0]       WrData = 32'h0;
    logic [31:0]       RdData;
    logic              Stall;
    logic              MisalignErr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic              mem_ack = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] model_rd = 32'h0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
        .Stall(Stall), .MisalignErr(MisalignErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return 1'b0;
        if (f3[1:0] == 2'b01) return a[0];
        return (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic [31:0] b;
        logic [31:0] h;
        bsh = rd >> (8 * a[1:0]);
        hsh = rd >> (16 * a[1]);
        b = bsh & 32'h0000_00FF;
        h = hsh & 32'h0000_FFFF;
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] model_fields(input logic wr, input logic [2:0] f3,
                                                 input logic [31:0] a);
        logic [3:0]  be;
        logic [31:0] wa;
        if (!wr)                    be = 4'b1111;
        else if (f3[1:0] == 2'b00)  be = 4'(1 << a[1:0]);
        else if (f3[1:0] == 2'b01)  be = a[1] ? 4'b1100 : 4'b0011;
        else                        be = 4'b1111;
        wa = (a >> 2) & 32'h0000_01FF;
        return {18'h0, wr, be, wa[8:0]};
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] b;
        logic [31:0] h;
        b = wd & 32'h0000_00FF;
        h = wd & 32'h0000_FFFF;
        if (f3[1:0] == 2'b00) return b * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return h * 32'h0001_0001;
        return wd;
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE.
    task automatic acc(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits);
        exp_t e;
        bit   trap_hit;
        bit   done;
        int   n_req;
        int   n_stall;
        trap_hit = TRAP && is_misaligned(f3, a);
        MemRead  = !wr;
        MemWrite = wr;
        Funct3   = f3;
        Addr     = a;
        WrData   = wd;
        if (trap_hit) model_rd = 32'h0;
        else if (!wr) model_rd = model_load(f3, a, rd);
        e.rd     = model_rd;
        e.mis    = trap_hit;
        e.chk_rd = trap_hit || !wr;
        sb_q.push_back(e);
        #1 chk("stall_c0", {31'h0, Stall}, 32'h1);
        n_req = 0;
        n_stall = 1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!Stall) begin
                done = 1'b1;
                chk("req_in_done", {31'h0, mem_req}, 32'h0);
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'h1, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk_rd) chk("rddata", RdData, e.rd);
                    chk("misalign", {31'h0, MisalignErr}, {31'h0, e.mis});
                end
            end else begin
                n_stall++;
                if (mem_req) begin
                    n_req++;
                    chk("mem_fields", {18'h0, mem_we, mem_be, mem_addr}, model_fields(wr, f3, a));
                    if (wr) chk("mem_wdata", mem_wdata, model_wdata(f3, wd));
                    if (n_req == waits + 1) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                    end
                end
            end
        end
        if (!done) chk("done_timeout", 32'h0, 32'h1);
        chk("req_cycles", 32'(n_req), trap_hit ? 32'h0 : 32'(waits + 1));
        chk("stall_cycles", 32'(n_stall), trap_hit ? 32'h1 : 32'(waits + 2));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        MemRead = 1'b1;
        Funct3  = 3'b010;
        Addr    = 32'h0000_0200;
        repeat (2) @(negedge clk);
        chk("rst_rddata", RdData, 32'h0);
        chk("rst_misalign", {31'h0, MisalignErr}, 32'h0);
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_fields", {18'h0, mem_we, mem_be, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_stall", {31'h0, Stall}, 32'h1);
        rst_n = 1'b1;
        acc(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 0);

        acc(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0, 0);
        acc(1'b1, 3'b001, 32'h0000_0102, 32'h1234_CAFE, 32'h0, 1);
        acc(1'b1, 3'b001, 32'h0000_0100, 32'h0000_5A5A, 32'h0, 0);
        acc(1'b1, 3'b010, 32'hFFFF_F7FC, 32'h0123_4567, 32'h0, 2);
        acc(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h1180_2233, 0);
        acc(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h1180_2233, 0);
        acc(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h1180_2233, 0);
        acc(1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_F00D, 0);
        acc(1'b0, 3'b001, 32'h0000_0100, 32'h0, 32'h1234_8001, 1);
        acc(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0);
        acc(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 3);
        acc(1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h89AB_CDEF, 0);
        acc(1'b0, 3'b110, 32'h0000_0014, 32'h0, 32'h7654_3210, 1);
        acc(1'b0, 3'b111, 32'h8000_0018, 32'h0, 32'h0F0F_F0F0, 0);
        acc(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0BAD_BEEF, 0);
        acc(1'b1, 3'b001, 32'h0000_0101, 32'h0000_BEEF, 32'h0, 0);
        acc(1'b0, 3'b101, 32'h0000_0103, 32'h0, 32'hA5C3_1234, 0);

        // Abandon a load in WAIT and deliver a stale ack after reset release.
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Funct3   = 3'b010;
        Addr     = 32'h0000_0300;
        repeat (3) @(negedge clk);
        chk("wait_req", {31'h0, mem_req}, 32'h1);
        rst_n = 1'b0;
        #1 chk("rst_async_req", {31'h0, mem_req}, 32'h0);
        MemRead  = 1'b0;
        model_rd = 32'h0;
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55AA_55AA;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stale_ack_req", {31'h0, mem_req}, 32'h0);
        chk("stale_ack_rd", RdData, model_rd);
        chk("stale_ack_stall", {31'h0, Stall}, 32'h0);
        @(negedge clk);
        chk("stale_ack_idle_rd", RdData, model_rd);
        acc(1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h1357_9BDF, 1);

        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
